// File: rtl/irq_pend_latch.sv
// Sticky interrupt capture feeding an external 8-to-3 priority encoder, with a valid/ready grant handshake.
// Define IRQ_EDGE_EN for rising-edge capture of irq_in; the default build captures in level mode.
module irq_pend_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       ovf_clr,
  output logic [7:0] pend_o,
  input  logic       enc_valid,
  input  logic [2:0] enc_y,
  output logic       grant_valid,
  input  logic       grant_ready,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic [7:0] overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pend;
  logic [7:0] r_ovf;
  logic [2:0] r_grantIdx;
  logic       r_grantValid;

  logic [7:0] w_setVec;
  logic [7:0] w_clrVec;
  logic [7:0] w_ovfSet;
  logic       w_accept;

`ifdef IRQ_EDGE_EN
  logic [7:0] r_irqPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irqPrev <= 8'd0;
    end else begin
      r_irqPrev <= irq_in;
    end
  end

  assign w_setVec = irq_in & ~r_irqPrev;
`else
  assign w_setVec = irq_in;
`endif

  assign w_accept = r_grantValid & grant_ready;
  assign w_clrVec = w_accept ? (8'd1 << r_grantIdx) : 8'd0;
  // A bit being serviced this cycle is not an overflow even if it re-arrives.
  assign w_ovfSet = w_setVec & r_pend & ~w_clrVec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 8'd0;
      r_ovf  <= 8'd0;
    end else begin
      r_pend <= (r_pend & ~w_clrVec) | w_setVec;
      r_ovf  <= ovf_clr ? w_ovfSet : (r_ovf | w_ovfSet);
    end
  end

  // Encoder feedback is only consulted in IDLE, so an offer is never preempted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grantIdx   <= 3'd0;
      r_grantValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enc_valid) begin
            r_grantIdx   <= enc_y;
            r_grantValid <= 1'b1;
            r_state      <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            r_grantValid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_grantValid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign pend_o      = r_pend;
  assign overflow    = r_ovf;
  assign grant_valid = r_grantValid;
  assign grant_idx   = r_grantIdx;
  assign busy        = |r_pend;

endmodule

// File: tb/tb_irq_pend_latch.sv
// Self-checking bench for irq_pend_latch with a behavioural priority encoder (highest index wins).
// Honours IRQ_EDGE_EN to select the expected held-line behaviour.
module tb_irq_pend_latch;

  logic       clk;
  logic       rst;
  logic [7:0] irqIn;
  logic       ovfClr;
  logic [7:0] pendO;
  logic       encValid;
  logic [2:0] encY;
  logic       grantValid;
  logic       grantReady;
  logic [2:0] grantIdx;
  logic       busy;
  logic [7:0] overflow;

  int checks   = 0;
  int failures = 0;
  logic [2:0] expQ[$];

  irq_pend_latch dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irqIn),
    .ovf_clr    (ovfClr),
    .pend_o     (pendO),
    .enc_valid  (encValid),
    .enc_y      (encY),
    .grant_valid(grantValid),
    .grant_ready(grantReady),
    .grant_idx  (grantIdx),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational 8-to-3 encoder: highest set bit wins.
  always_comb begin
    encValid = |pendO;
    encY     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pendO[i]) encY = 3'(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irqIn      = 8'd0;
    ovfClr     = 1'b0;
    grantReady = 1'b0;
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    irqIn      = 8'hFF;
    ovfClr     = 1'b0;
    grantReady = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pendO !== 8'd0) begin failures++; $display("[TB] FAIL reset_pend got=%h exp=00", pendO); end
    checks++; if (overflow !== 8'd0) begin failures++; $display("[TB] FAIL reset_ovf got=%h exp=00", overflow); end
    checks++; if (grantValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_gv got=%b exp=0", grantValid); end
    checks++; if (grantIdx !== 3'd0) begin failures++; $display("[TB] FAIL reset_idx got=%0d exp=0", grantIdx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    tick();
    checks++; if (pendO !== 8'hFF) begin failures++; $display("[TB] FAIL reset_e1_pend got=%h exp=ff", pendO); end
    checks++; if (grantValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_e1_gv got=%b exp=0", grantValid); end
    tick();
    checks++; if (grantValid !== 1'b1) begin failures++; $display("[TB] FAIL reset_e2_gv got=%b exp=1", grantValid); end
    checks++; if (grantIdx !== 3'd7) begin failures++; $display("[TB] FAIL reset_e2_idx got=%0d exp=7", grantIdx); end
    irqIn = 8'd0;
  endtask

  task automatic test_pulse();
    logic [7:0] pendExp[6] = '{8'h24, 8'h24, 8'h04, 8'h04, 8'h00, 8'h00};
    logic [2:0] exp;
    int lastGrant = -10;
    do_reset();
    grantReady = 1'b1;
    irqIn      = 8'h24;
    expQ.push_back(3'd5);
    expQ.push_back(3'd2);
    for (int c = 0; c < 8; c++) begin
      tick();
      irqIn = 8'd0;
      if (c < 6) begin
        checks++;
        if (pendO !== pendExp[c] || busy !== (pendExp[c] != 8'd0)) begin
          failures++;
          $display("[TB] FAIL pulse_pend c=%0d got=%h/%b exp=%h", c, pendO, busy, pendExp[c]);
        end
      end
      if (grantValid && grantReady) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++; $display("[TB] FAIL pulse_extra_grant got=%0d exp=none", grantIdx);
        end else begin
          exp = expQ.pop_front();
          if (grantIdx !== exp || (lastGrant >= 0 && c - lastGrant != 2)) begin
            failures++;
            $display("[TB] FAIL pulse_grant got=%0d gap=%0d exp=%0d gap=2", grantIdx, c - lastGrant, exp);
          end
        end
        lastGrant = c;
      end
    end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL pulse_missing got=%0d left exp=0", expQ.size()); end
  endtask

  task automatic test_no_preempt();
    logic [2:0] exp;
    do_reset();
    irqIn = 8'h04;
    tick();
    irqIn = 8'd0;
    tick();
    checks++; if (grantValid !== 1'b1 || grantIdx !== 3'd2) begin failures++; $display("[TB] FAIL np_offer got=%b/%0d exp=1/2", grantValid, grantIdx); end
    irqIn = 8'h80;
    tick();
    irqIn = 8'd0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (grantValid !== 1'b1 || grantIdx !== 3'd2) begin
        failures++; $display("[TB] FAIL np_hold c=%0d got=%b/%0d exp=1/2", c, grantValid, grantIdx);
      end
      tick();
    end
    expQ.push_back(3'd2);
    expQ.push_back(3'd7);
    grantReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (grantValid && grantReady) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++; $display("[TB] FAIL np_extra_grant got=%0d exp=none", grantIdx);
        end else begin
          exp = expQ.pop_front();
          if (grantIdx !== exp) begin failures++; $display("[TB] FAIL np_grant got=%0d exp=%0d", grantIdx, exp); end
        end
      end
      tick();
    end
    checks++; if (expQ.size() != 0 || pendO !== 8'd0) begin failures++; $display("[TB] FAIL np_drain got=%0d/%h exp=0/00", expQ.size(), pendO); end
  endtask

  task automatic test_overflow();
    do_reset();
    irqIn = 8'h08;
    tick();
    irqIn = 8'd0;
    checks++; if (overflow !== 8'd0) begin failures++; $display("[TB] FAIL ovf_first got=%h exp=00", overflow); end
    tick();
    irqIn = 8'h08;
    tick();
    irqIn = 8'd0;
    checks++; if (overflow !== 8'h08) begin failures++; $display("[TB] FAIL ovf_set got=%h exp=08", overflow); end
    tick();
    checks++; if (overflow !== 8'h08) begin failures++; $display("[TB] FAIL ovf_sticky got=%h exp=08", overflow); end
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checks++; if (overflow !== 8'd0) begin failures++; $display("[TB] FAIL ovf_clr got=%h exp=00", overflow); end
    irqIn  = 8'h08;
    ovfClr = 1'b1;
    tick();
    irqIn  = 8'd0;
    ovfClr = 1'b0;
    checks++; if (overflow !== 8'h08) begin failures++; $display("[TB] FAIL ovf_set_wins got=%h exp=08", overflow); end
  endtask

  task automatic test_same_cycle();
    logic [2:0] exp;
    do_reset();
    irqIn = 8'h10;
    tick();
    irqIn = 8'd0;
    tick();
    expQ.push_back(3'd4);
    checks++; if (grantValid !== 1'b1 || grantIdx !== 3'd4) begin failures++; $display("[TB] FAIL sc_offer got=%b/%0d exp=1/4", grantValid, grantIdx); end
    grantReady = 1'b1;
    irqIn      = 8'h10;
    exp = expQ.pop_front();
    tick();
    grantReady = 1'b0;
    irqIn      = 8'd0;
    checks++; if (pendO[4] !== 1'b1 || overflow[4] !== 1'b0 || grantValid !== 1'b0) begin
      failures++; $display("[TB] FAIL sc_accept got=pend%h ovf%h gv%b exp=pend10 ovf00 gv0", pendO, overflow, grantValid);
    end
    expQ.push_back(3'd4);
    tick();
    exp = expQ.pop_front();
    checks++; if (grantValid !== 1'b1 || grantIdx !== exp) begin failures++; $display("[TB] FAIL sc_reoffer got=%b/%0d exp=1/%0d", grantValid, grantIdx, exp); end
  endtask

  task automatic test_held();
    int grants = 0;
    int lastGrant = -10;
    int expGrants;
    logic [7:0] expOvf;
`ifdef IRQ_EDGE_EN
    expGrants = 1;
    expOvf    = 8'h00;
`else
    expGrants = 5;
    expOvf    = 8'h02;
`endif
    do_reset();
    grantReady = 1'b1;
    irqIn      = 8'h02;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (grantValid && grantReady) begin
        checks++;
        if (grantIdx !== 3'd1 || (grants > 0 && c - lastGrant != 2)) begin
          failures++; $display("[TB] FAIL held_grant got=%0d gap=%0d exp=1 gap=2", grantIdx, c - lastGrant);
        end
        grants++;
        lastGrant = c;
      end
      if (c == 10) irqIn = 8'd0;
    end
    checks++; if (grants != expGrants) begin failures++; $display("[TB] FAIL held_count got=%0d exp=%0d", grants, expGrants); end
    checks++; if (overflow !== expOvf || pendO !== 8'd0) begin failures++; $display("[TB] FAIL held_end got=ovf%h pend%h exp=ovf%h pend00", overflow, pendO, expOvf); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    irqIn = 8'h08;
    tick();
    irqIn = 8'd0;
    tick();
    irqIn = 8'h08;
    tick();
    irqIn = 8'd0;
    checks++; if (grantValid !== 1'b1 || overflow !== 8'h08) begin failures++; $display("[TB] FAIL rmo_pre got=%b/%h exp=1/08", grantValid, overflow); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (grantValid !== 1'b0 || pendO !== 8'd0 || overflow !== 8'd0 || busy !== 1'b0 || grantIdx !== 3'd0) begin
      failures++; $display("[TB] FAIL rmo_async got=gv%b pend%h ovf%h busy%b idx%0d exp=all0", grantValid, pendO, overflow, busy, grantIdx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    irqIn      = 8'd0;
    ovfClr     = 1'b0;
    grantReady = 1'b0;
    test_reset();
    test_pulse();
    test_no_preempt();
    test_overflow();
    test_same_cycle();
    test_held();
    test_reset_mid_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pend_latch.md
# irq_pend_latch

Sticky interrupt-request capture and grant sequencer. It sits directly upstream of the 8-to-3 priority encoder:
- Drives the encoder's 8-bit request input from a pending register.
- Takes the encoder's valid/index result back.
- Offers the winning index downstream over a valid/ready handshake, holding it stable until taken.
- Clears the serviced pending bit on acceptance.

## Interface
- No parameters; width fixed at 8 request lines, 3-bit index.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  8  raw request lines, sampled on rising clk.
- ovf_clr  input  1  one-cycle pulse; clears all overflow flags.
- pend_o  output  8  pending register; drives encoder request input.
- enc_valid  input  1  encoder valid (at least one pend_o bit set).
- enc_y  input  3  encoder index; ignored when enc_valid=0 (may be X).
- grant_valid  output  1  grant_idx is being offered.
- grant_ready  input  1  consumer accepts the offered grant.
- grant_idx  output  3  registered index being offered.
- busy  output  1  |pend_o (combinational).
- overflow  output  8  sticky per-line flag: request re-arrived while still pending.

## Operation
- set_vec: per-line set request derived from irq_in (see Configuration).
- clr_vec: one-hot (1 << grant_idx) in the cycle grant_valid & grant_ready; zero otherwise.
- pend update each edge: pend <= (pend & ~clr_vec) | set_vec. Set wins over clear on the same bit in the same cycle; the bit stays pending.
- overflow[i] is set when set_vec[i] & pend[i] & ~clr_vec[i].
- overflow is cleared by ovf_clr. A set in the same cycle as ovf_clr wins.
- FSM, two states:
  - IDLE: grant_valid=0. If enc_valid, latch grant_idx <= enc_y and go to OFFER; else stay.
  - OFFER: grant_valid=1, grant_idx held. If grant_ready, assert clr_vec and go to IDLE; else stay.
- grant_idx and grant_valid never change while grant_valid=1 and grant_ready=0. A higher-priority request arriving during OFFER does not preempt; it waits for the next IDLE.
- enc_valid/enc_y are looked at only in IDLE.
- Encoder feedback is assumed consistent with pend_o in the same cycle (combinational encoder).

## Timing
- Reset values: pend_o=0, overflow=0, grant_valid=0, grant_idx=0, busy=0, FSM=IDLE; the edge-detect history register (when IRQ_EDGE_EN is defined) is also 0.
- Reset asserted mid-offer drops grant_valid immediately (asynchronous). Pending requests are lost.
- Request sampled at edge N: pend bit is set after N; FSM enters OFFER at edge N+1; grant_valid is high in the cycle after N+1. Latency is 2 edges.
- Acceptance at edge M clears the bit and returns the FSM to IDLE. The next offer, if any pend bit remains, is visible after edge M+1.
- Maximum throughput: one grant per 2 cycles.
- All outputs except busy are registered.

## Configuration
- IRQ_EDGE_EN defined:
  - set_vec = irq_in & ~irq_prev, where irq_prev is a registered copy of irq_in.
  - A held-high line produces exactly one pending set per 0->1 transition.
- IRQ_EDGE_EN undefined:
  - set_vec = irq_in (level mode); irq_prev is not built.
  - A held-high line re-sets its bit every cycle, so it re-pends immediately after service and flags overflow each cycle while already pending.

## Test plan
- Reset with irq_in=8'hFF held, then release rst: all outputs 0 at release. After 2 edges, grant_valid=1 and grant_idx=7.
- Pulse irq_in=8'h24 for one cycle, hold grant_ready=1:
  - Grants issued are idx 5, then idx 2, each 2 cycles apart.
  - pend_o sequence: 8'h24, 8'h04, 8'h00; busy falls with it.
- Hold grant_ready=0 with idx 2 offered, then pulse irq 7: grant_idx stays 2 until accepted; next grant is 7.
- Pulse irq 3 twice while bit 3 is still pending: overflow=8'h08. An ovf_clr pulse returns it to 0.
- Same-cycle accept of idx 4 and a new irq 4 set: pend_o[4] stays 1, overflow[4] stays 0, and idx 4 is re-offered.
- Hold irq_in[1]=1 for 10 cycles with grant_ready=1:
  - IRQ_EDGE_EN defined: exactly one grant of idx 1.
  - IRQ_EDGE_EN undefined: one grant every 2 cycles.
- Assert rst mid-OFFER: grant_valid, pend_o and overflow go to 0 asynchronously.
